laser_pool: RTL and testbench
=============================

# laser_pool

Parametrised pool of `NUM_LASERS` independent player lasers for the space-invaders datapath. It replaces the single-laser tracker. It detects fire presses and spawns a laser into the lowest free slot, subject to a cooldown. On each movement tick it steps every active laser toward x = 0 and retires lasers that leave the screen or are killed by the collision unit. The per-slot position and active vectors feed the renderer and the collision checker.

## Interface
- `NUM_LASERS`, 4: number of slots (1..8).
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `X_START`, 155: spawn x position; also the x reported by an idle slot.
- `STEP`, 2: pixels subtracted per `move_tick` (1..7).
- `COOLDOWN`, 8: cycles after an accepted fire during which fire edges are rejected (0 disables).

- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high; clears all slots and counters.
- `fire` in 1: level input from the space bar; the block acts on its rising edge.
- `y_init` in `Y_W`: y of the ship, captured at spawn and held for the laser's life.
- `move_tick` in 1: single-cycle frame/move strobe.
- `kill` in `NUM_LASERS`: per-slot hit pulse from the collision unit.
- `x_pos` out `NUM_LASERS*X_W`: packed x positions; slot i occupies `[i*X_W +: X_W]`.
- `y_pos` out `NUM_LASERS*Y_W`: packed y positions, same packing as `x_pos`.
- `active` out `NUM_LASERS`: slot-occupied flags.
- `fire_ack` out 1: one-cycle pulse when a spawn is accepted.
- `fire_drop` out 1: one-cycle pulse when a fire edge is rejected (pool full or cooldown).
- `count` out `$clog2(NUM_LASERS+1)`: number of active slots.

## Operation
- Edge detect: a rising edge is the cycle in which `fire`=1 and the registered previous `fire`=0. The previous-value register resets to 0, so holding `fire` high through reset release produces an edge on the first post-reset cycle.
- Spawn: on an edge with cooldown counter = 0 and at least one inactive slot, the lowest-index inactive slot loads `x=X_START`, `y=y_init`, `active=1`. The block then pulses `fire_ack` and loads the cooldown counter with `COOLDOWN`.
- Reject: on an edge while cooldown ≠ 0 or all slots are active, no state changes except that `fire_drop` pulses.
- Cooldown: the counter decrements by 1 each cycle while nonzero, independent of `move_tick`.
- Move: on `move_tick`, every active slot that is not being killed checks its x position.
  - If `x < STEP`, the slot retires.
  - Otherwise `x ← x − STEP`.
  - The subtraction is unsigned `X_W`-bit and never wraps.
- Kill: `kill[i]`=1 on an active slot retires it. `kill[i]` on an inactive slot is ignored.
- Retire: the slot sets `active=0`, `x=X_START`, `y=0`.
- Idle slot outputs are always `x=X_START`, `y=0`.
- `count` equals the popcount of the registered `active` vector.

Simultaneous events:
- Kill and move on the same slot: kill wins; the slot retires.
- Spawn and move in the same cycle: the new laser appears at `X_START` unmoved; other slots move normally.
- Kill and spawn: a slot killed this cycle is not free for a spawn until the next cycle. Free-slot selection uses the start-of-cycle `active` vector.
- Reset mid-flight: all slots retire, cooldown = 0, pulses = 0, at the next edge.

## Timing
- All outputs are registered.
- Reset values: `x_pos` = `X_START` in every slot, `y_pos` = 0, `active` = 0, `count` = 0, `fire_ack` = 0, `fire_drop` = 0.
- Fire edge sampled at edge t: the slot state and `fire_ack`/`fire_drop` are visible after edge t, for one cycle.
- Latency from the `fire` 0→1 input change to `active` set is one clock.
- Move, kill and retire effects are visible one clock after the sampled strobe.
- With defaults, a laser reports x = 155, 153, …, 1 over 78 ticks and retires on the 78th `move_tick` after spawn.

## Structure
- Package `laser_pkg` holds the default constants (`X_START`, `STEP`, `COOLDOWN`, widths) and a slot-state struct (`active`, `x`, `y`).
- Sub-module `laser_slot`, instantiated `NUM_LASERS` times, holds one slot's registers. It has inputs `spawn`, `move`, `kill`, `y_init` and outputs `x`, `y`, `active`.
- The top level holds the edge detector, cooldown counter, lowest-free priority encoder, pulse registers and popcount.

## Test plan
- Reset then single press: `y_init`=60, `fire` 0→1 → slot 0 `active`=1, x=155, y=60; `fire_ack` pulses once; `count`=1.
- Flight and exit: 78 `move_tick`s after a spawn → x steps 155→1, then slot 0 retires to x=155, y=0, `count`=0.
- Cooldown: second press 3 cycles after the first (COOLDOWN=8) → `fire_drop` pulses and no spawn. A press 9 cycles after the first → slot 1 spawns.
- Full pool: 5 spaced presses with NUM_LASERS=4 → slots 0–3 active, 5th press gives `fire_drop`. Then `kill`=4'b0010 → slot 1 free; the next press fills slot 1.
- Collisions: `kill[0]` and `move_tick` in the same cycle → slot 0 retires, not moved. A spawn in the same cycle as `move_tick` → new laser at 155, existing lasers decrease by 2.
- Reset mid-flight with 3 active lasers → all outputs return to reset values one cycle later; a held `fire` produces an edge right after reset deasserts.

Source files
------------

// File: rtl/laser_pool_pkg.sv
// Shared defaults and slot-state type for the laser pool.
`timescale 1ns/1ps
package laser_pkg;
    localparam int NUM_LASERS_D = 4;
    localparam int X_W_D        = 8;
    localparam int Y_W_D        = 7;
    localparam int X_START_D    = 155;
    localparam int STEP_D       = 2;
    localparam int COOLDOWN_D   = 8;

    typedef struct packed {
        logic             active;
        logic [X_W_D-1:0] x;
        logic [Y_W_D-1:0] y;
    } slot_t;
endpackage

// File: rtl/laser_pool_if.sv
// Fire/move/kill inputs and per-slot position/status outputs of the laser pool.
`timescale 1ns/1ps
interface laser_pool_if
    import laser_pkg::*;
#(
    parameter int NUM_LASERS = NUM_LASERS_D,
    parameter int X_W        = X_W_D,
    parameter int Y_W        = Y_W_D
);
    localparam int CNT_W = $clog2(NUM_LASERS + 1);

    logic                      fire;
    logic [Y_W-1:0]            y_init;
    logic                      move_tick;
    logic [NUM_LASERS-1:0]     kill;
    logic [NUM_LASERS*X_W-1:0] x_pos;
    logic [NUM_LASERS*Y_W-1:0] y_pos;
    logic [NUM_LASERS-1:0]     active;
    logic                      fire_ack;
    logic                      fire_drop;
    logic [CNT_W-1:0]          count;

    modport master (
        output fire, y_init, move_tick, kill,
        input  x_pos, y_pos, active, fire_ack, fire_drop, count
    );

    modport slave (
        input  fire, y_init, move_tick, kill,
        output x_pos, y_pos, active, fire_ack, fire_drop, count
    );
endinterface

// File: rtl/laser_slot.sv
// One laser slot: spawns at X_START, steps toward x=0 on move, retires on kill or exit.
// Latency 1 cycle from spawn/move/kill to updated outputs; no backpressure.
`timescale 1ns/1ps
module laser_slot #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int X_START = 155,
    parameter int STEP    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spawn,
    input  logic           move,
    input  logic           kill,
    input  logic [Y_W-1:0] y_init,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           active
);
    localparam logic [X_W-1:0] X_START_V = X_W'(X_START);
    localparam logic [X_W-1:0] STEP_V    = X_W'(STEP);

    logic retire;

    // Kill beats move; a step that would go below zero retires instead of wrapping.
    assign retire = active && (kill || (move && (x < STEP_V)));

    always_ff @(posedge clk) begin
        if (reset || retire) begin
            active <= 1'b0;
            x      <= X_START_V;
            y      <= '0;
        end else if (spawn) begin
            active <= 1'b1;
            x      <= X_START_V;
            y      <= y_init;
        end else if (active && move) begin
            x <= x - STEP_V;
        end
    end
endmodule

// File: rtl/laser_pool.sv
// Pool of player lasers: fire edge detect, cooldown, lowest-free slot spawn, popcount.
// Latency 1 cycle from sampled fire/move/kill to outputs; rejected fires pulse fire_drop.
`timescale 1ns/1ps
module laser_pool
    import laser_pkg::*;
#(
    parameter int NUM_LASERS = NUM_LASERS_D,
    parameter int X_W        = X_W_D,
    parameter int Y_W        = Y_W_D,
    parameter int X_START    = X_START_D,
    parameter int STEP       = STEP_D,
    parameter int COOLDOWN   = COOLDOWN_D
) (
    input  logic         clk,
    input  logic         reset,
    laser_pool_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_LASERS + 1);
    // Extra headroom keeps the counter at least one bit wide when COOLDOWN is 0.
    localparam int CD_W  = $clog2(COOLDOWN + 2);

    logic                      fire_q;
    logic                      fire_edge;
    logic                      accept;
    logic [CD_W-1:0]           cd;
    logic                      ack_q;
    logic                      drop_q;
    logic [NUM_LASERS-1:0]     act;
    logic [NUM_LASERS-1:0]     free;
    logic [NUM_LASERS-1:0]     spawn_vec;
    logic [NUM_LASERS*X_W-1:0] x_bus;
    logic [NUM_LASERS*Y_W-1:0] y_bus;
    logic [CNT_W-1:0]          cnt;

    assign fire_edge = bus.fire & ~fire_q;
    assign free      = ~act;
    assign accept    = fire_edge && (cd == '0) && (|free);
    // Isolate the lowest set bit of the free mask taken from the start-of-cycle state.
    assign spawn_vec = accept ? (free & (-free)) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_q <= 1'b0;
            cd     <= '0;
            ack_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            fire_q <= bus.fire;
            ack_q  <= accept;
            drop_q <= fire_edge && !accept;
            if (accept) begin
                cd <= CD_W'(COOLDOWN);
            end else if (cd != '0) begin
                cd <= cd - CD_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_LASERS; i++) begin : g_slot
        laser_slot #(
            .X_W     (X_W),
            .Y_W     (Y_W),
            .X_START (X_START),
            .STEP    (STEP)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .spawn  (spawn_vec[i]),
            .move   (bus.move_tick),
            .kill   (bus.kill[i]),
            .y_init (bus.y_init),
            .x      (x_bus[i*X_W +: X_W]),
            .y      (y_bus[i*Y_W +: Y_W]),
            .active (act[i])
        );
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_LASERS; i++) begin
            cnt = cnt + CNT_W'(act[i]);
        end
    end

    assign bus.x_pos     = x_bus;
    assign bus.y_pos     = y_bus;
    assign bus.active    = act;
    assign bus.fire_ack  = ack_q;
    assign bus.fire_drop = drop_q;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_laser_pool.sv
// Directed bench for laser_pool with a per-cycle reference model and literal spot checks.
`timescale 1ns/1ps
module tb_laser_pool;
    import laser_pkg::*;

    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    laser_pool_if #(.NUM_LASERS(NL), .X_W(8), .Y_W(7)) bus ();

    laser_pool dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: slot array updated from the rules, one step per clock.
    slot_t m [NL];
    int    m_cd;
    int    fs;
    int    nx;
    bit    m_prev, m_ack, m_drop, fe, model_on;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NL; i++) m[i] = '{1'b0, 8'(X_START_D), 7'd0};
            m_cd = 0; m_prev = 0; m_ack = 0; m_drop = 0; model_on = 1;
        end else begin
            fe = bus.fire && !m_prev;
            fs = -1;
            for (int i = NL - 1; i >= 0; i--) if (!m[i].active) fs = i;
            m_ack  = fe && (m_cd == 0) && (fs >= 0);
            m_drop = fe && !m_ack;
            if (m_ack) m_cd = COOLDOWN_D;
            else if (m_cd > 0) m_cd = m_cd - 1;
            for (int i = 0; i < NL; i++) begin
                if (m[i].active) begin
                    nx = int'(m[i].x) - STEP_D;
                    if (bus.kill[i] || (bus.move_tick && nx < 0))
                        m[i] = '{1'b0, 8'(X_START_D), 7'd0};
                    else if (bus.move_tick)
                        m[i].x = 8'(nx);
                end
            end
            if (m_ack) m[fs] = '{1'b1, 8'(X_START_D), bus.y_init};
            m_prev = bus.fire;
        end
    end

    logic [31:0] ex;
    logic [27:0] ey;
    logic [3:0]  ea;
    int          ec;

    always @(negedge clk) begin
        if (model_on) begin
            ec = 0;
            for (int i = 0; i < NL; i++) begin
                ex[i*8 +: 8] = m[i].x;
                ey[i*7 +: 7] = m[i].y;
                ea[i]        = m[i].active;
                ec           = ec + int'(m[i].active);
            end
            chk("model_x_pos",  bus.x_pos,     ex);
            chk("model_y_pos",  bus.y_pos,     ey);
            chk("model_active", bus.active,    ea);
            chk("model_count",  bus.count,     ec);
            chk("model_ack",    bus.fire_ack,  m_ack);
            chk("model_drop",   bus.fire_drop, m_drop);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] y, input bit exp_ack, input string nm);
        bus.y_init = y;
        bus.fire   = 1'b1;
        cyc();
        chk(nm, {bus.fire_ack, bus.fire_drop}, exp_ack ? 2'b10 : 2'b01);
        bus.fire = 1'b0;
        repeat (9) cyc();
    endtask

    initial begin
        bus.fire = 1'b0; bus.y_init = '0; bus.move_tick = 1'b0; bus.kill = '0;
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_active", bus.active, 4'b0000);
        chk("rst_count",  bus.count,  0);
        chk("rst_x",      bus.x_pos,  32'h9B9B9B9B);
        chk("rst_y",      bus.y_pos,  0);
        chk("rst_pulses", {bus.fire_ack, bus.fire_drop}, 2'b00);
        rst = 1'b0;

        // Single press, then cooldown reject at +3 and accept at +9.
        bus.y_init = 7'd60; bus.fire = 1'b1;
        cyc();
        chk("p1_active", bus.active, 4'b0001);
        chk("p1_x0",     bus.x_pos[7:0], 155);
        chk("p1_y0",     bus.y_pos[6:0], 60);
        chk("p1_ack",    bus.fire_ack, 1);
        chk("p1_count",  bus.count, 1);
        bus.fire = 1'b0;
        cyc();
        chk("p1_ack_once", bus.fire_ack, 0);
        cyc();
        bus.fire = 1'b1;
        cyc();
        chk("cd_drop",   {bus.fire_ack, bus.fire_drop}, 2'b01);
        chk("cd_active", bus.active, 4'b0001);
        bus.fire = 1'b0;
        repeat (5) cyc();
        bus.fire = 1'b1; bus.y_init = 7'd33;
        cyc();
        chk("cd_accept", {bus.fire_ack, bus.fire_drop}, 2'b10);
        chk("cd_slot1",  bus.active, 4'b0011);
        bus.fire = 1'b0;
        cyc();

        // Flight: 77 ticks reach x=1, the 78th retires.
        for (int k = 1; k <= 78; k++) begin
            bus.move_tick = 1'b1;
            cyc();
            bus.move_tick = 1'b0;
            if (k == 77) chk("flight_x1", bus.x_pos[7:0], 1);
            if (k == 77) chk("flight_live", bus.active, 4'b0011);
            cyc();
        end
        chk("exit_active", bus.active, 4'b0000);
        chk("exit_count",  bus.count, 0);
        chk("exit_x",      bus.x_pos, 32'h9B9B9B9B);

        // Full pool.
        press(7'd10, 1, "fill0");
        press(7'd20, 1, "fill1");
        press(7'd30, 1, "fill2");
        press(7'd40, 1, "fill3");
        chk("full_active", bus.active, 4'b1111);
        chk("full_count",  bus.count, 4);
        press(7'd50, 0, "full_drop");
        bus.kill = 4'b0010;
        cyc();
        bus.kill = '0;
        chk("kill1_active", bus.active, 4'b1101);
        press(7'd70, 1, "refill1");
        chk("refill_active", bus.active, 4'b1111);
        chk("refill_y1",     bus.y_pos[13:7], 70);

        // Kill and spawn together: killed slot not yet free.
        bus.kill = 4'b0001; bus.fire = 1'b1;
        cyc();
        bus.kill = '0; bus.fire = 1'b0;
        chk("killspawn_drop",   {bus.fire_ack, bus.fire_drop}, 2'b01);
        chk("killspawn_active", bus.active, 4'b1110);
        repeat (9) cyc();

        // Kill and move on the same slot.
        bus.kill = 4'b0010; bus.move_tick = 1'b1;
        cyc();
        bus.kill = '0; bus.move_tick = 1'b0;
        chk("killmove_active", bus.active, 4'b1100);
        chk("killmove_x",      bus.x_pos, 32'h99999B9B);

        // Spawn together with move.
        bus.fire = 1'b1; bus.move_tick = 1'b1; bus.y_init = 7'd5;
        cyc();
        bus.fire = 1'b0; bus.move_tick = 1'b0;
        chk("spawnmove_active", bus.active, 4'b1101);
        chk("spawnmove_x",      bus.x_pos, 32'h97979B9B);
        chk("spawnmove_ack",    bus.fire_ack, 1);
        bus.kill = 4'b0010;
        cyc();
        bus.kill = '0;
        chk("kill_idle", bus.active, 4'b1101);

        // Reset mid-flight with fire held through release.
        rst = 1'b1; bus.fire = 1'b1;
        cyc();
        chk("mid_rst_active", bus.active, 4'b0000);
        chk("mid_rst_count",  bus.count, 0);
        chk("mid_rst_x",      bus.x_pos, 32'h9B9B9B9B);
        chk("mid_rst_y",      bus.y_pos, 0);
        chk("mid_rst_pulses", {bus.fire_ack, bus.fire_drop}, 2'b00);
        rst = 1'b0;
        cyc();
        chk("post_rst_active", bus.active, 4'b0001);
        chk("post_rst_ack",    bus.fire_ack, 1);
        bus.fire = 1'b0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
